// File: rtl/axis_demux_dma_src.sv
// rtl/axis_demux_dma_src.sv - descriptor-driven demux of one AXI-Stream into N_SPLIT_CHAN streams
// Each accepted descriptor steers data.len+1 input beats to axis_out[chan]; out-of-range chan drains.
module axis_demux_dma_src #(
  parameter int N_SPLIT_CHAN  = 4,
  parameter int MUX_DATA_BITS = 64,
  parameter int LEN_BITS      = 16,
  localparam int BLEN_BITS    = LEN_BITS - $clog2(MUX_DATA_BITS/8),
  // one extra bit so chan == N_SPLIT_CHAN (drain) is representable
  localparam int CHAN_BITS    = $clog2(N_SPLIT_CHAN) + 1
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic                                         mux_valid,
  output logic                                         mux_ready,
  input  logic [CHAN_BITS-1:0]                         mux_chan,
  input  logic [BLEN_BITS-1:0]                         mux_len,
  input  logic                                         mux_last,
  input  logic [MUX_DATA_BITS-1:0]                     axis_in_tdata,
  input  logic [MUX_DATA_BITS/8-1:0]                   axis_in_tkeep,
  input  logic                                         axis_in_tvalid,
  output logic                                         axis_in_tready,
  input  logic                                         axis_in_tlast,
  output logic [N_SPLIT_CHAN-1:0][MUX_DATA_BITS-1:0]   axis_out_tdata,
  output logic [N_SPLIT_CHAN-1:0][MUX_DATA_BITS/8-1:0] axis_out_tkeep,
  output logic [N_SPLIT_CHAN-1:0]                      axis_out_tvalid,
  input  logic [N_SPLIT_CHAN-1:0]                      axis_out_tready,
  output logic [N_SPLIT_CHAN-1:0]                      axis_out_tlast
);

  typedef enum logic {ST_IDLE, ST_DEMUX} state_t;

  state_t               state_C, state_N;
  logic [CHAN_BITS-1:0] id_C, id_N;
  logic [BLEN_BITS-1:0] cnt_C, cnt_N;
  logic                 sel_valid;
  logic                 beat;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, mux_last, axis_in_tlast};
  assign sel_valid = (id_C < CHAN_BITS'(N_SPLIT_CHAN));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_C <= ST_IDLE;
      id_C    <= '0;
      cnt_C   <= '0;
    end else begin
      state_C <= state_N;
      id_C    <= id_N;
      cnt_C   <= cnt_N;
    end
  end

  always_comb begin
    state_N         = state_C;
    id_N            = id_C;
    cnt_N           = cnt_C;
    mux_ready       = 1'b0;
    axis_in_tready  = 1'b0;
    axis_out_tdata  = '0;
    axis_out_tkeep  = '0;
    axis_out_tvalid = '0;
    axis_out_tlast  = '0;
    beat            = 1'b0;
    case (state_C)
      ST_IDLE: begin
        mux_ready = mux_valid;
        if (mux_valid) begin
          id_N    = mux_chan;
          cnt_N   = mux_len;
          state_N = ST_DEMUX;
        end
      end
      ST_DEMUX: begin
        // Drain mode: accept everything, present nothing.
        axis_in_tready = !sel_valid;
        for (int i = 0; i < N_SPLIT_CHAN; i++) begin
          if (sel_valid && id_C == CHAN_BITS'(i)) begin
            axis_out_tvalid[i] = axis_in_tvalid;
            axis_out_tdata[i]  = axis_in_tdata;
            axis_out_tkeep[i]  = axis_in_tkeep;
            axis_out_tlast[i]  = (cnt_C == '0);
            axis_in_tready     = axis_out_tready[i];
          end
        end
        beat = axis_in_tvalid && axis_in_tready;
        if (beat) begin
          if (cnt_C != '0) begin
            cnt_N = cnt_C - BLEN_BITS'(1);
          end else if (mux_valid) begin
            mux_ready = 1'b1;
            id_N      = mux_chan;
            cnt_N     = mux_len;
          end else begin
            state_N = ST_IDLE;
          end
        end
      end
      default: state_N = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_demux_dma_src.sv
// tb/tb_axis_demux_dma_src.sv - randomized bench for axis_demux_dma_src with a beat-list reference model
module tb_axis_demux_dma_src;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int KW   = W / 8;
  localparam int LB   = 12;
  localparam int BLEN = LB - $clog2(KW);
  localparam int CB   = $clog2(N) + 1;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic                  mux_valid = 1'b0;
  logic                  mux_ready;
  logic [CB-1:0]         mux_chan = '0;
  logic [BLEN-1:0]       mux_len = '0;
  logic                  mux_last = 1'b0;
  logic [W-1:0]          axis_in_tdata = '0;
  logic [KW-1:0]         axis_in_tkeep = '0;
  logic                  axis_in_tvalid = 1'b0;
  logic                  axis_in_tready;
  logic                  axis_in_tlast = 1'b0;
  logic [N-1:0][W-1:0]   axis_out_tdata;
  logic [N-1:0][KW-1:0]  axis_out_tkeep;
  logic [N-1:0]          axis_out_tvalid;
  logic [N-1:0]          axis_out_tready = '0;
  logic [N-1:0]          axis_out_tlast;

  axis_demux_dma_src #(.N_SPLIT_CHAN(N), .MUX_DATA_BITS(W), .LEN_BITS(LB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_chan(mux_chan),
    .mux_len(mux_len), .mux_last(mux_last),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tlast(axis_in_tlast),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tlast(axis_out_tlast)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: descriptors expanded into a flat list of expected beats.
  int           d_chan[$];
  int           d_len[$];
  logic [W-1:0] b_data[$];
  logic [KW-1:0] b_keep[$];
  int           b_chan[$];
  bit           b_last[$];
  int           desc_idx, beat_idx, acc_end;
  int           p_valid, p_ready;
  bit           mux_hold;

  task automatic reset_model();
    d_chan.delete(); d_len.delete();
    b_data.delete(); b_keep.delete(); b_chan.delete(); b_last.delete();
    desc_idx = 0; beat_idx = 0; acc_end = 0; mux_hold = 0;
  endtask

  task automatic add_desc(input int c, input int l);
    d_chan.push_back(c);
    d_len.push_back(l);
    for (int k = 0; k <= l; k++) begin
      b_data.push_back(W'($urandom));
      b_keep.push_back(KW'($urandom));
      b_chan.push_back(c);
      b_last.push_back(k == l);
    end
  endtask

  task automatic drive();
    mux_valid = (desc_idx < d_chan.size()) && (mux_hold || ($urandom % 100 < p_valid));
    mux_chan  = mux_valid ? CB'(d_chan[desc_idx]) : CB'($urandom);
    mux_len   = mux_valid ? BLEN'(d_len[desc_idx]) : BLEN'($urandom);
    mux_last  = 1'($urandom);
    axis_in_tvalid = (beat_idx < b_data.size()) && ($urandom % 100 < p_valid);
    axis_in_tdata  = (beat_idx < b_data.size()) ? b_data[beat_idx] : W'($urandom);
    axis_in_tkeep  = (beat_idx < b_data.size()) ? b_keep[beat_idx] : KW'($urandom);
    axis_in_tlast  = 1'($urandom);
    for (int i = 0; i < N; i++) axis_out_tready[i] = ($urandom % 100 < p_ready);
  endtask

  task automatic run(input int max_cycles, input int stop_beat);
    int  owed, ch;
    bit  exp_tready, exp_hs, exp_mr, sel, exp_v, done;
    done = 0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if ((desc_idx == d_chan.size() && beat_idx == b_data.size()) || beat_idx >= stop_beat) begin
        done = 1;
        break;
      end
      @(negedge aclk);
      owed       = acc_end - beat_idx;
      ch         = (owed > 0) ? b_chan[beat_idx] : -1;
      exp_tready = (owed > 0) && (ch >= N || axis_out_tready[ch]);
      exp_hs     = axis_in_tvalid && exp_tready;
      exp_mr     = mux_valid && (owed == 0 || (exp_hs && b_last[beat_idx]));
      chk("in_tready", 64'(axis_in_tready), 64'(exp_tready));
      chk("mux_ready", 64'(mux_ready), 64'(exp_mr));
      for (int i = 0; i < N; i++) begin
        sel   = (owed > 0) && (ch == i);
        exp_v = sel && axis_in_tvalid;
        chk("out_tvalid", 64'(axis_out_tvalid[i]), 64'(exp_v));
        chk("out_tlast", 64'(axis_out_tlast[i]), 64'(sel && b_last[beat_idx]));
        if (exp_v) begin
          chk("out_tdata", 64'(axis_out_tdata[i]), 64'(b_data[beat_idx]));
          chk("out_tkeep", 64'(axis_out_tkeep[i]), 64'(b_keep[beat_idx]));
        end else if (!sel) begin
          chk("idle_tdata", 64'(axis_out_tdata[i]), 64'(0));
          chk("idle_tkeep", 64'(axis_out_tkeep[i]), 64'(0));
        end
      end
      @(posedge aclk);
      #1;
      mux_hold = mux_valid && !exp_mr;
      if (exp_mr) begin
        acc_end += d_len[desc_idx] + 1;
        desc_idx++;
      end
      if (exp_hs) beat_idx++;
      drive();
    end
    if (!done && !((desc_idx == d_chan.size() && beat_idx == b_data.size()) || beat_idx >= stop_beat))
      chk("timeout", 64'(0), 64'(1));
  endtask

  task automatic quiet_check(input string tag);
    chk({tag, "_in_tready"}, 64'(axis_in_tready), 64'(0));
    chk({tag, "_mux_ready"}, 64'(mux_ready), 64'(0));
    chk({tag, "_tvalid"}, 64'(axis_out_tvalid), 64'(0));
    chk({tag, "_tlast"}, 64'(axis_out_tlast), 64'(0));
  endtask

  initial begin
    reset_model();
    p_valid = 100; p_ready = 100;
    axis_in_tvalid = 1'b1;
    axis_out_tready = '1;
    repeat (2) @(posedge aclk);
    #1;
    quiet_check("reset");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    quiet_check("post_reset");

    // 4 beats to out[2], tlast on the last only
    reset_model(); add_desc(2, 3); drive(); run(50, 1 << 30);
    // back-to-back descriptors, no bubble between bursts
    reset_model(); add_desc(0, 1); add_desc(1, 0); drive(); run(50, 1 << 30);
    // output stalls mid-burst
    reset_model(); p_ready = 50; add_desc(1, 4); drive(); run(200, 1 << 30);
    // out-of-range channel drains, then back to idle
    reset_model(); p_ready = 100; add_desc(N, 2); drive(); run(50, 1 << 30);
    axis_in_tvalid = 1'b1;
    #1;
    quiet_check("drain_idle");

    // reset abandons a burst after two beats
    reset_model(); add_desc(3, 7); drive(); run(50, 2);
    mux_valid = 1'b0;
    axis_in_tvalid = 1'b1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    quiet_check("mid_reset");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    quiet_check("after_mid_reset");
    reset_model(); add_desc(0, 0); drive(); run(50, 1 << 30);

    // randomized descriptors, in- and out-of-range channels, random backpressure
    reset_model(); p_valid = 70; p_ready = 70;
    for (int j = 0; j < 40; j++) add_desc($urandom_range(0, N), $urandom_range(0, 5));
    add_desc($urandom_range(0, N - 1), 20);
    drive(); run(5000, 1 << 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
